matrix_mul_seq: RTL and testbench



---
 rtl/matrix_mul_seq_if.sv | 17 +
 rtl/matrix_mul_seq.sv | 154 +++++++++++++++
 tb/tb_matrix_mul_seq.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_mul_seq_if.sv
// Handshake and flattened-matrix bus for the sequential matrix multiplier.
// The master issues operands and start; the slave reports busy/done and the result.
interface matrix_mul_seq_if #(
  parameter int unsigned N     = 2,
  parameter int unsigned W     = 32,
  parameter int unsigned OUT_W = 32
);
  logic                 start;
  logic [N*N*W-1:0]     mat_a;
  logic [N*N*W-1:0]     mat_b;
  logic                 busy;
  logic                 done;
  logic [N*N*OUT_W-1:0] mat_out;

  modport master (output start, mat_a, mat_b, input busy, done, mat_out);
  modport slave  (input start, mat_a, mat_b, output busy, done, mat_out);
endinterface

// File: rtl/matrix_mul_seq.sv
// Sequential N x N matrix multiplier: one shared MAC, N^3 compute cycles,
// start/busy/done handshake, result committed atomically and held until the next commit.
module matrix_mul_seq #(
  parameter int unsigned N      = 2,
  parameter int unsigned W      = 32,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned SIGNED = 0
) (
  input logic            clk,
  input logic            rst,
  matrix_mul_seq_if.slave mm_if
);
  localparam int unsigned IW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW  = 2 * W;
  localparam bit          SGN = (SIGNED != 0);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_e;

  state_e               state_q, state_d;
  logic [W-1:0]         a_q   [N][N];
  logic [W-1:0]         a_d   [N][N];
  logic [W-1:0]         b_q   [N][N];
  logic [W-1:0]         b_d   [N][N];
  logic [OUT_W-1:0]     res_q [N][N];
  logic [OUT_W-1:0]     res_d [N][N];
  logic [OUT_W-1:0]     acc_q, acc_d;
  logic [IW-1:0]        i_q, i_d, k_q, k_d, j_q, j_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [N*N*OUT_W-1:0] out_q, out_d;

  logic [W-1:0]         a_el_c, b_el_c;
  logic [PW-1:0]        a_ext_c, b_ext_c, prod_c;
  logic [OUT_W-1:0]     prod_ext_c, acc_sum_c;

  // Extending both operands to 2W first makes one unsigned multiplier serve both signednesses.
  assign a_el_c  = a_q[i_q][j_q];
  assign b_el_c  = b_q[j_q][k_q];
  assign a_ext_c = {{W{SGN & a_el_c[W-1]}}, a_el_c};
  assign b_ext_c = {{W{SGN & b_el_c[W-1]}}, b_el_c};
  assign prod_c  = a_ext_c * b_ext_c;

  if (OUT_W > PW) begin : g_ext
    assign prod_ext_c = {{(OUT_W-PW){SGN & prod_c[PW-1]}}, prod_c};
  end else begin : g_trunc
    assign prod_ext_c = prod_c[OUT_W-1:0];
  end

  assign acc_sum_c = acc_q + prod_ext_c;

  assign mm_if.busy    = busy_q;
  assign mm_if.done    = done_q;
  assign mm_if.mat_out = out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      i_q     <= '0;
      k_q     <= '0;
      j_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      for (int unsigned r = 0; r < N; r++) begin
        for (int unsigned c = 0; c < N; c++) begin
          a_q[r][c]   <= '0;
          b_q[r][c]   <= '0;
          res_q[r][c] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      k_q     <= k_d;
      j_q     <= j_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  // Loop order: i (row), k (column), j (inner, fastest).
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    acc_d   = acc_q;
    i_d     = i_q;
    k_d     = k_q;
    j_d     = j_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    out_d   = out_q;

    unique case (state_q)
      IDLE: begin
        if (mm_if.start) begin
          for (int unsigned r = 0; r < N; r++) begin
            for (int unsigned c = 0; c < N; c++) begin
              a_d[r][c] = mm_if.mat_a[(r*N+c)*W +: W];
              b_d[r][c] = mm_if.mat_b[(r*N+c)*W +: W];
            end
          end
          acc_d   = '0;
          i_d     = '0;
          k_d     = '0;
          j_d     = '0;
          busy_d  = 1'b1;
          state_d = COMPUTE;
        end
      end

      COMPUTE: begin
        busy_d = 1'b1;
        if (j_q == IW'(N - 1)) begin
          res_d[i_q][k_q] = acc_sum_c;
          acc_d = '0;
          j_d   = '0;
          if (k_q == IW'(N - 1)) begin
            k_d = '0;
            if (i_q == IW'(N - 1)) begin
              // Final element lands in res_d, so the whole buffer commits in one edge.
              i_d     = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = DONE;
              for (int unsigned r = 0; r < N; r++) begin
                for (int unsigned c = 0; c < N; c++) begin
                  out_d[(r*N+c)*OUT_W +: OUT_W] = res_d[r][c];
                end
              end
            end else begin
              i_d = i_q + IW'(1);
            end
          end else begin
            k_d = k_q + IW'(1);
          end
        end else begin
          acc_d = acc_sum_c;
          j_d   = j_q + IW'(1);
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_matrix_mul_seq.sv
// Scoreboard bench for matrix_mul_seq: unsigned/signed 8->16 bit instances sharing stimulus,
// plus a default-parameter instance, all checked against an integer reference model.
module tb_matrix_mul_seq;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [127:0] exp_u[$];
  logic [127:0] exp_s[$];
  logic [127:0] exp_d[$];

  matrix_mul_seq_if #(.N(2), .W(8),  .OUT_W(16)) if_u ();
  matrix_mul_seq_if #(.N(2), .W(8),  .OUT_W(16)) if_s ();
  matrix_mul_seq_if #(.N(2), .W(32), .OUT_W(32)) if_d ();

  assign if_s.start = if_u.start;
  assign if_s.mat_a = if_u.mat_a;
  assign if_s.mat_b = if_u.mat_b;

  matrix_mul_seq #(.N(2), .W(8),  .OUT_W(16), .SIGNED(0)) dut_u (.clk(clk), .rst(rst), .mm_if(if_u));
  matrix_mul_seq #(.N(2), .W(8),  .OUT_W(16), .SIGNED(1)) dut_s (.clk(clk), .rst(rst), .mm_if(if_s));
  matrix_mul_seq #(.N(2), .W(32), .OUT_W(32), .SIGNED(0)) dut_d (.clk(clk), .rst(rst), .mm_if(if_d));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Element idx of a flattened bus, as a mathematical integer.
  function automatic longint elem(input logic [127:0] p, input int idx, input int w, input bit sgn);
    logic [63:0] m;
    logic [63:0] raw;
    m   = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    raw = 64'(p >> (idx * w)) & m;
    if (sgn && raw[w-1]) raw = raw | ~m;
    return longint'(raw);
  endfunction

  // Exact integer dot products, then reduced modulo 2^ow.
  function automatic logic [127:0] ref_mm(input logic [127:0] pa, input logic [127:0] pb,
                                          input int w, input int ow, input bit sgn);
    logic [127:0] r;
    logic [127:0] msk;
    longint       s;
    r   = '0;
    msk = (128'd1 << ow) - 128'd1;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 2; k++) begin
        s = 0;
        for (int j = 0; j < 2; j++) s += elem(pa, i*2+j, w, sgn) * elem(pb, j*2+k, w, sgn);
        r = r | ((128'(s) & msk) << ((i*2+k) * ow));
      end
    end
    return r;
  endfunction

  task automatic wait_idle_u();
    int n = 0;
    while ((if_u.busy || if_u.done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_u reached", 128'(if_u.busy || if_u.done), 128'(0));
  endtask

  task automatic wait_idle_d();
    int n = 0;
    while ((if_d.busy || if_d.done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("idle_d reached", 128'(if_d.busy || if_d.done), 128'(0));
  endtask

  task automatic wait_done_u(output int c);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if_u.done && n < 50);
    check("done_u seen", 128'(if_u.done), 128'(1));
    c = cyc;
  endtask

  task automatic wait_done_d(output int c);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if_d.done && n < 50);
    check("done_d seen", 128'(if_d.done), 128'(1));
    c = cyc;
  endtask

  task automatic issue_us(input logic [31:0] pa, input logic [31:0] pb, input bit wait_result);
    int c;
    wait_idle_u();
    if_u.mat_a = pa;
    if_u.mat_b = pb;
    if_u.start = 1'b1;
    exp_u.push_back(ref_mm(128'(pa), 128'(pb), 8, 16, 1'b0));
    exp_s.push_back(ref_mm(128'(pa), 128'(pb), 8, 16, 1'b1));
    @(negedge clk);
    if_u.start = 1'b0;
    if_u.mat_a = ~pa;
    if_u.mat_b = $urandom;
    check("busy_u after accept", 128'(if_u.busy), 128'(1));
    if (wait_result) wait_done_u(c);
  endtask

  task automatic issue_d(input logic [127:0] pa, input logic [127:0] pb);
    int c;
    wait_idle_d();
    if_d.mat_a = pa;
    if_d.mat_b = pb;
    if_d.start = 1'b1;
    exp_d.push_back(ref_mm(pa, pb, 32, 32, 1'b0));
    @(negedge clk);
    if_d.start = 1'b0;
    if_d.mat_a = ~pa;
    check("busy_d after accept", 128'(if_d.busy), 128'(1));
    wait_done_d(c);
  endtask

  // Monitor for the unsigned 8->16 instance.
  initial begin
    logic [127:0] last = '0;
    int  bcnt = 0;
    bit  pbusy = 1'b0, pdone = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last = '0; bcnt = 0; pbusy = 1'b0; pdone = 1'b0;
        check("rst mat_out_u", 128'(if_u.mat_out), '0);
      end else begin
        if (if_u.done) begin
          check("busy_cycles_u", 128'(bcnt), 128'(8));
          check("done_pulse_u", 128'({pbusy, pdone, if_u.busy}), 128'(3'b100));
          if (exp_u.size() == 0) fail("unexpected done_u");
          else check("mat_out_u", 128'(if_u.mat_out), exp_u.pop_front());
          last = 128'(if_u.mat_out);
          bcnt = 0;
        end else begin
          check("hold_u", 128'(if_u.mat_out), last);
        end
        if (if_u.busy) bcnt++;
        pbusy = if_u.busy;
        pdone = if_u.done;
      end
    end
  end

  // Monitor for the signed 8->16 instance.
  initial begin
    logic [127:0] last = '0;
    int  bcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last = '0; bcnt = 0;
        check("rst mat_out_s", 128'(if_s.mat_out), '0);
      end else begin
        if (if_s.done) begin
          check("busy_cycles_s", 128'(bcnt), 128'(8));
          if (exp_s.size() == 0) fail("unexpected done_s");
          else check("mat_out_s", 128'(if_s.mat_out), exp_s.pop_front());
          last = 128'(if_s.mat_out);
          bcnt = 0;
        end else begin
          check("hold_s", 128'(if_s.mat_out), last);
        end
        if (if_s.busy) bcnt++;
      end
    end
  end

  // Monitor for the default-parameter instance.
  initial begin
    logic [127:0] last = '0;
    int  bcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last = '0; bcnt = 0;
        check("rst mat_out_d", if_d.mat_out, '0);
      end else begin
        if (if_d.done) begin
          check("busy_cycles_d", 128'(bcnt), 128'(8));
          if (exp_d.size() == 0) fail("unexpected done_d");
          else check("mat_out_d", if_d.mat_out, exp_d.pop_front());
          last = if_d.mat_out;
          bcnt = 0;
        end else begin
          check("hold_d", if_d.mat_out, last);
        end
        if (if_d.busy) bcnt++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0]  pa0, pa1, pb;
    int           c1, c2;

    rst        = 1'b1;
    if_u.start = 1'b0; if_u.mat_a = '0; if_u.mat_b = '0;
    if_d.start = 1'b0; if_d.mat_a = '0; if_d.mat_b = '0;
    repeat (3) @(negedge clk);
    check("reset busy_u", 128'(if_u.busy), 128'(0));
    check("reset done_u", 128'(if_u.done), 128'(0));
    check("reset busy_s", 128'(if_s.busy), 128'(0));
    check("reset busy_d", 128'(if_d.busy), 128'(0));
    check("reset done_d", 128'(if_d.done), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors: basic product, full-scale wrap, signed identity negation.
    issue_us({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b1);
    issue_us(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue_us({8'hFF, 8'h00, 8'h00, 8'hFF}, {8'd5, 8'd4, 8'd3, 8'd2}, 1'b1);

    for (int t = 0; t < 6; t++) issue_us($urandom, $urandom, 1'b1);

    // start held high: one result per 10 cycles, each using operands from its own accept edge.
    wait_idle_u();
    pa0 = $urandom; pa1 = $urandom; pb = $urandom;
    if_u.mat_a = pa0; if_u.mat_b = pb; if_u.start = 1'b1;
    exp_u.push_back(ref_mm(128'(pa0), 128'(pb), 8, 16, 1'b0));
    exp_s.push_back(ref_mm(128'(pa0), 128'(pb), 8, 16, 1'b1));
    exp_u.push_back(ref_mm(128'(pa1), 128'(pb), 8, 16, 1'b0));
    exp_s.push_back(ref_mm(128'(pa1), 128'(pb), 8, 16, 1'b1));
    repeat (3) @(negedge clk);
    if_u.mat_a = pa1;
    wait_done_u(c1);
    wait_done_u(c2);
    if_u.start = 1'b0;
    check("held start period", 128'(c2 - c1), 128'(10));

    // Asynchronous reset mid-computation discards the pending result.
    issue_us($urandom, $urandom, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst busy_u", 128'(if_u.busy), 128'(0));
    check("async rst done_u", 128'(if_u.done), 128'(0));
    check("async rst mat_out_u", 128'(if_u.mat_out), '0);
    check("async rst busy_s", 128'(if_s.busy), 128'(0));
    check("async rst mat_out_s", 128'(if_s.mat_out), '0);
    exp_u.delete();
    exp_s.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    issue_us({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b1);

    for (int t = 0; t < 8; t++)
      issue_d({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});

    repeat (5) @(negedge clk);
    check("exp_u drained", 128'(exp_u.size()), 128'(0));
    check("exp_s drained", 128'(exp_s.size()), 128'(0));
    check("exp_d drained", 128'(exp_d.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
